// File: rtl/ram_responder_pkg.sv
// -----------------------------------------------------------------------------
// ram_responder_pkg
//   Shared definitions for the data-RAM responder: FSM state encoding,
//   default geometry of the strobe interface and the all-lanes byte enable.
// -----------------------------------------------------------------------------
package ram_responder_pkg;

    // Default geometry of the CPU data-RAM strobe interface.
    localparam int RAM_ADDR_W = 8;
    localparam int RAM_DATA_W = 32;

    // Four byte lanes; lane k covers data bits [8k+7:8k].
    localparam int RAM_BE_W = 4;
    localparam logic [RAM_BE_W-1:0] RAM_BE_ALL = 4'b1111;

    // Responder FSM states (2-bit encoding).
    typedef enum logic [1:0] {
        ST_INIT = 2'd0,  // zero-filling the array after reset
        ST_IDLE = 2'd1,  // accepting requests
        ST_SWAP = 2'd2   // second half of an atomic swap (deferred write)
    } state_t;

endpackage : ram_responder_pkg

// File: rtl/ram_responder_word_array.sv
// -----------------------------------------------------------------------------
// ram_responder_word_array
//   DEPTH x DATA_W synchronous word array with per-byte-lane write enables,
//   one write port and one synchronous read port.
//
// Ports
//   clk      in   rising-edge clock
//   wr_en    in   write strobe
//   wr_addr  in   write word address
//   wr_be    in   byte-lane enables for the write
//   wr_data  in   write data
//   rd_en    in   load rd_data from mem[rd_addr]
//   rd_clr   in   load rd_data with zero (takes priority over rd_en)
//   rd_addr  in   read word address
//   rd_data  out  registered read data; holds when neither rd_en nor rd_clr
// -----------------------------------------------------------------------------
module ram_responder_word_array
    import ram_responder_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DEPTH  = 256,
    parameter int DATA_W = RAM_DATA_W
) (
    input  logic                clk,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [RAM_BE_W-1:0] wr_be,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                rd_en,
    input  logic                rd_clr,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [DATA_W-1:0]   rd_data
);

    // NOTE: the storage array has no reset; clearing it is the responder's
    // job (INIT sweep), which keeps this mappable onto block RAM.
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [DATA_W-1:0] rd_data_d;
    logic [DATA_W-1:0] rd_data_q;

    // Byte-lane write: only enabled lanes are touched, others keep their value.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < RAM_BE_W; k++) begin
                if (wr_be[k]) begin
                    mem_q[wr_addr][8*k +: 8] <= wr_data[8*k +: 8];
                end
            end
        end
    end

    // NOTE: every combinational output gets a default first so no latch is
    // inferred when neither rd_clr nor rd_en is asserted.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_clr) begin
            rd_data_d = '0;
        end else if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops
    // update together on the edge, independent of block ordering.
    always_ff @(posedge clk) begin
        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule : ram_responder_word_array

// File: rtl/ram_responder.sv
// -----------------------------------------------------------------------------
// ram_responder
//   Memory-side end of the CPU data-RAM strobe interface. Services
//   single-cycle reads and byte-lane writes; RD and WR together form an
//   atomic swap (old word returned, new word written one cycle later).
//   The array is zero-filled, one word per cycle, after every reset.
//
// Ports
//   iCLK        in   clock, all logic on the rising edge
//   iRST        in   synchronous active-low reset
//   iRAM_CE     in   request strobe
//   iRAM_RD     in   read request (with iRAM_WR: atomic swap)
//   iRAM_WR     in   write request
//   iRAM_ADDR   in   word address
//   iRAM_BE     in   byte-lane write enables
//   iRAM_DATA   in   write data
//   oRAM_DATA   out  registered read data, holds until the next read/swap
//   oRAM_READY  out  one-cycle completion pulse
//   oRAM_BUSY   out  1 while requests are being ignored (INIT, SWAP)
//   oRAM_ERR    out  address >= DEPTH; pulses together with oRAM_READY
//
// DATA_W must be 32: the byte-lane logic assumes four 8-bit lanes.
// -----------------------------------------------------------------------------
module ram_responder
    import ram_responder_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DEPTH  = 256,
    parameter int DATA_W = RAM_DATA_W
) (
    input  logic                iCLK,
    input  logic                iRST,
    input  logic                iRAM_CE,
    input  logic                iRAM_RD,
    input  logic                iRAM_WR,
    input  logic [ADDR_W-1:0]   iRAM_ADDR,
    input  logic [RAM_BE_W-1:0] iRAM_BE,
    input  logic [DATA_W-1:0]   iRAM_DATA,
    output logic [DATA_W-1:0]   oRAM_DATA,
    output logic                oRAM_READY,
    output logic                oRAM_BUSY,
    output logic                oRAM_ERR
);

    // Last address swept by INIT, and DEPTH widened by one bit so the range
    // check also works when DEPTH == 2**ADDR_W.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);

    // FSM state and registered outputs.
    state_t              state_q,    state_d;
    logic [ADDR_W-1:0]   init_cnt_q, init_cnt_d;
    logic                ready_q,    ready_d;
    logic                err_q,      err_d;
    logic                busy_q,     busy_d;

    // Swap latches: the deferred write of an atomic swap.
    logic [ADDR_W-1:0]   swap_addr_q, swap_addr_d;
    logic [DATA_W-1:0]   swap_data_q, swap_data_d;
    logic [RAM_BE_W-1:0] swap_be_q,   swap_be_d;
    logic                swap_err_q,  swap_err_d;

    // Array control.
    logic                arr_wr_en;
    logic [ADDR_W-1:0]   arr_wr_addr;
    logic [RAM_BE_W-1:0] arr_wr_be;
    logic [DATA_W-1:0]   arr_wr_data;
    logic                arr_rd_en;
    logic                arr_rd_clr;
    logic [DATA_W-1:0]   arr_rd_data;

    logic req_valid;
    logic addr_ok;

    assign req_valid = iRAM_CE & (iRAM_RD | iRAM_WR);
    assign addr_ok   = ({1'b0, iRAM_ADDR} < DEPTH_X);

    // -------------------------------------------------------------------------
    // Next-state and array control
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        ready_d     = 1'b0;
        err_d       = 1'b0;
        swap_addr_d = swap_addr_q;
        swap_data_d = swap_data_q;
        swap_be_d   = swap_be_q;
        swap_err_d  = swap_err_q;
        arr_wr_en   = 1'b0;
        arr_wr_addr = iRAM_ADDR;
        arr_wr_be   = iRAM_BE;
        arr_wr_data = iRAM_DATA;
        arr_rd_en   = 1'b0;
        arr_rd_clr  = 1'b0;

        unique case (state_q)
            ST_INIT: begin
                // Zero one word per cycle, 0..DEPTH-1.
                arr_wr_en   = 1'b1;
                arr_wr_addr = init_cnt_q;
                arr_wr_be   = RAM_BE_ALL;
                arr_wr_data = '0;
                if (init_cnt_q == LAST_ADDR) begin
                    init_cnt_d = '0;
                    state_d    = ST_IDLE;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end

            ST_IDLE: begin
                if (req_valid) begin
                    // Reads and swaps sample the old word now; an out-of-range
                    // address loads zero instead of touching the array.
                    if (iRAM_RD) begin
                        arr_rd_en  = addr_ok;
                        arr_rd_clr = ~addr_ok;
                    end
                    if (iRAM_RD && iRAM_WR) begin
                        // Write half is deferred to SWAP so the read sees the
                        // pre-swap contents.
                        swap_addr_d = iRAM_ADDR;
                        swap_data_d = iRAM_DATA;
                        swap_be_d   = iRAM_BE;
                        swap_err_d  = ~addr_ok;
                        state_d     = ST_SWAP;
                    end else begin
                        arr_wr_en = iRAM_WR & addr_ok;
                        ready_d   = 1'b1;
                        err_d     = ~addr_ok;
                    end
                end
            end

            ST_SWAP: begin
                arr_wr_en   = ~swap_err_q;
                arr_wr_addr = swap_addr_q;
                arr_wr_be   = swap_be_q;
                arr_wr_data = swap_data_q;
                ready_d     = 1'b1;
                err_d       = swap_err_q;
                state_d     = ST_IDLE;
            end

            default: begin
                state_d    = ST_INIT;
                init_cnt_d = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // -------------------------------------------------------------------------
    // FSM and registered outputs (synchronous active-low reset)
    // -------------------------------------------------------------------------
    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
        end
    end

    // Swap latches are pure datapath; they are only consumed in SWAP, which
    // is always entered through IDLE, so they carry no reset.
    always_ff @(posedge iCLK) begin
        swap_addr_q <= swap_addr_d;
        swap_data_q <= swap_data_d;
        swap_be_q   <= swap_be_d;
        swap_err_q  <= swap_err_d;
    end

    // -------------------------------------------------------------------------
    // Word array. Reset gates every array write (so a swap caught by reset
    // never lands) and clears the read register to give oRAM_DATA = 0.
    // -------------------------------------------------------------------------
    ram_responder_word_array #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_array (
        .clk     (iCLK),
        .wr_en   (arr_wr_en & iRST),
        .wr_addr (arr_wr_addr),
        .wr_be   (arr_wr_be),
        .wr_data (arr_wr_data),
        .rd_en   (arr_rd_en & iRST),
        .rd_clr  (arr_rd_clr | ~iRST),
        .rd_addr (iRAM_ADDR),
        .rd_data (arr_rd_data)
    );

    assign oRAM_DATA  = arr_rd_data;
    assign oRAM_READY = ready_q;
    assign oRAM_BUSY  = busy_q;
    assign oRAM_ERR   = err_q;

endmodule : ram_responder
